button_conditioner: RTL and testbench

Front-end conditioning stage that sits directly upstream of the digital lock top level. It takes the raw push-button and switch inputs from the board (mod3, mod10, confirm, enter, mode, reset buttons). It synchronises each input to clk_125Mhz, debounces it with a per-channel state machine, and produces a clean debounced level plus a single-cycle press pulse. Selected channels also emit hold-to-repeat pulses, so a held mod10 button steps the digit. A global enable blanks all pulses while the security lockout is active.

---
 rtl/button_conditioner.sv | 124 ++++++++++++
 tb/tb_button_conditioner.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: two-flop synchroniser, per-channel debounce FSM, registered level,
// single-cycle press pulse and optional hold-to-repeat pulses, all pulses gated by enable.
module button_conditioner #(
  parameter int unsigned      N_BTN           = 6,
  parameter int unsigned      DEBOUNCE_CYCLES = 1250000,
  parameter int unsigned      HOLD_CYCLES     = 62500000,
  parameter int unsigned      REPEAT_CYCLES   = 25000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = 6'b000010,
  parameter int unsigned      CNT_W           = 26
) (
  input  logic             clk_125Mhz,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             enable,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  localparam logic [CNT_W-1:0] DebLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldLast  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RepReload = CNT_W'(HOLD_CYCLES - REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntZero   = '0;

  typedef enum logic [1:0] {StReleased, StPressWait, StPressed, StReleaseWait} state_e;

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] pulse_int_d, pulse_int_q;
  logic [N_BTN-1:0] level_q, pulse_q;
  state_e           state_q [N_BTN];
  state_e           state_d [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];
  logic [CNT_W-1:0] cnt_d   [N_BTN];

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i]     = state_q[i];
      cnt_d[i]       = cnt_q[i];
      pulse_int_d[i] = 1'b0;
      case (state_q[i])
        StReleased: begin
          if (sync2_q[i]) begin
            state_d[i] = StPressWait;
            cnt_d[i]   = CntOne;
          end else begin
            cnt_d[i] = CntZero;
          end
        end
        StPressWait: begin
          if (!sync2_q[i]) begin
            state_d[i] = StReleased;
            cnt_d[i]   = CntZero;
          end else if (cnt_q[i] == DebLast) begin
            state_d[i]     = StPressed;
            cnt_d[i]       = CntZero;
            pulse_int_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        StPressed: begin
          if (!sync2_q[i]) begin
            state_d[i] = StReleaseWait;
            cnt_d[i]   = CntOne;
          end else if (REPEAT_MASK[i]) begin
            // Reload rather than clear so later repeats arrive every REPEAT_CYCLES.
            if (cnt_q[i] == HoldLast) begin
              pulse_int_d[i] = 1'b1;
              cnt_d[i]       = RepReload;
            end else begin
              cnt_d[i] = cnt_q[i] + CntOne;
            end
          end else begin
            cnt_d[i] = CntZero;
          end
        end
        StReleaseWait: begin
          if (sync2_q[i]) begin
            state_d[i] = StPressed;
            cnt_d[i]   = CntZero;
          end else if (cnt_q[i] == DebLast) begin
            state_d[i] = StReleased;
            cnt_d[i]   = CntZero;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        default: begin
          state_d[i] = StReleased;
          cnt_d[i]   = CntZero;
        end
      endcase
    end
  end

  always_ff @(posedge clk_125Mhz) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      pulse_int_q <= '0;
      level_q     <= '0;
      pulse_q     <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= StReleased;
        cnt_q[i]   <= CntZero;
      end
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      pulse_int_q <= pulse_int_d;
      // Suppressed pulses are dropped, not queued.
      pulse_q     <= pulse_int_q & {N_BTN{enable}};
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        level_q[i] <= (state_q[i] == StPressed) || (state_q[i] == StReleaseWait);
      end
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/hold/repeat timing.
module tb_button_conditioner;

  logic       clk_125Mhz = 1'b0;
  logic       rst        = 1'b1;
  logic [5:0] btn_raw    = '0;
  logic       enable     = 1'b1;
  logic [5:0] btn_level;
  logic [5:0] btn_pulse;

  int n_vec = 0;
  int n_err = 0;

  button_conditioner #(
    .N_BTN          (6),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (12),
    .REPEAT_CYCLES  (5),
    .REPEAT_MASK    (6'b000010),
    .CNT_W          (5)
  ) dut (
    .clk_125Mhz(clk_125Mhz),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .enable    (enable),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse)
  );

  always #4 clk_125Mhz = ~clk_125Mhz;

  // Advance one rising edge and settle; "cycle n" is the value seen after relative edge n.
  task automatic tick();
    @(posedge clk_125Mhz);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    btn_raw = '0;
    enable  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    btn_raw = 6'b111111;
    for (int n = 0; n < 4; n++) begin
      tick();
      n_vec++;
      if (btn_level !== 6'b0 || btn_pulse !== 6'b0) begin
        n_err++;
        $display("FAIL reset n=%0d level=%b pulse=%b required 000000/000000", n, btn_level,
                 btn_pulse);
      end
    end
    btn_raw = '0;
    rst     = 1'b0;
    for (int n = 0; n < 8; n++) begin
      tick();
      n_vec++;
      if (btn_level !== 6'b0 || btn_pulse !== 6'b0) begin
        n_err++;
        $display("FAIL reset_idle n=%0d level=%b pulse=%b required 000000/000000", n,
                 btn_level, btn_pulse);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [5:0] ep, el;
    do_reset();
    for (int n = 0; n < 32; n++) begin
      btn_raw = (n < 20) ? 6'b000100 : 6'b000000;
      tick();
      ep = (n == 6) ? 6'b000100 : 6'b000000;
      el = (n >= 6 && n < 26) ? 6'b000100 : 6'b000000;
      n_vec++;
      if (btn_pulse !== ep || btn_level !== el) begin
        n_err++;
        $display("FAIL clean_press n=%0d pulse=%b level=%b required %b/%b", n, btn_pulse,
                 btn_level, ep, el);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int n = 0; n < 16; n++) begin
      btn_raw = (n < 3) ? 6'b001000 : 6'b000000;
      tick();
      n_vec++;
      if (btn_pulse !== 6'b0 || btn_level !== 6'b0) begin
        n_err++;
        $display("FAIL glitch n=%0d pulse=%b level=%b required 000000/000000", n, btn_pulse,
                 btn_level);
      end
    end
  endtask

  task automatic test_repeat();
    logic [5:0] ep, el;
    do_reset();
    for (int n = 0; n < 50; n++) begin
      btn_raw = (n < 40) ? 6'b000011 : 6'b000000;
      tick();
      ep = '0;
      if (n == 6) ep = 6'b000011;
      else if (n == 18 || n == 23 || n == 28 || n == 33 || n == 38) ep = 6'b000010;
      el = (n >= 6 && n < 46) ? 6'b000011 : 6'b000000;
      n_vec++;
      if (btn_pulse !== ep || btn_level !== el) begin
        n_err++;
        $display("FAIL repeat n=%0d pulse=%b level=%b required %b/%b", n, btn_pulse,
                 btn_level, ep, el);
      end
    end
  endtask

  task automatic test_enable_gating();
    logic [5:0] ep, el;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      btn_raw = (n < 20 || n >= 30) ? 6'b010000 : 6'b000000;
      enable  = (n >= 10);
      tick();
      ep = (n == 36) ? 6'b010000 : 6'b000000;
      el = ((n >= 6 && n < 26) || n >= 36) ? 6'b010000 : 6'b000000;
      n_vec++;
      if (btn_pulse !== ep || btn_level !== el) begin
        n_err++;
        $display("FAIL enable_gating n=%0d pulse=%b level=%b required %b/%b", n, btn_pulse,
                 btn_level, ep, el);
      end
    end
  endtask

  task automatic test_release_bounce();
    logic [5:0] ep, el;
    do_reset();
    for (int n = 0; n < 28; n++) begin
      btn_raw = (n < 12 || n == 14 || n == 15) ? 6'b000100 : 6'b000000;
      tick();
      ep = (n == 6) ? 6'b000100 : 6'b000000;
      el = (n >= 6 && n < 22) ? 6'b000100 : 6'b000000;
      n_vec++;
      if (btn_pulse !== ep || btn_level !== el) begin
        n_err++;
        $display("FAIL release_bounce n=%0d pulse=%b level=%b required %b/%b", n, btn_pulse,
                 btn_level, ep, el);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] ep, el;
    do_reset();
    for (int n = 0; n < 16; n++) begin
      btn_raw = 6'b100000;
      rst     = (n == 4);
      tick();
      ep = (n == 11) ? 6'b100000 : 6'b000000;
      el = (n >= 11) ? 6'b100000 : 6'b000000;
      n_vec++;
      if (btn_pulse !== ep || btn_level !== el) begin
        n_err++;
        $display("FAIL reset_mid n=%0d pulse=%b level=%b required %b/%b", n, btn_pulse,
                 btn_level, ep, el);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [5:0] ep, el;
    do_reset();
    for (int n = 0; n < 10; n++) begin
      btn_raw = 6'b001001;
      tick();
      ep = (n == 6) ? 6'b001001 : 6'b000000;
      el = (n >= 6) ? 6'b001001 : 6'b000000;
      n_vec++;
      if (btn_pulse !== ep || btn_level !== el) begin
        n_err++;
        $display("FAIL simultaneous n=%0d pulse=%b level=%b required %b/%b", n, btn_pulse,
                 btn_level, ep, el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_repeat();
    test_enable_gating();
    test_release_bounce();
    test_reset_mid();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
